// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the hazard sequencer and its hazard detector:
// FSM state type and encodings, register-address width and default timeout.
package hazard_sequencer_pkg;

  localparam int REG_ADDR_W      = 4;
  localparam int DEF_MEM_TIMEOUT = 15;
  localparam int DEF_WAIT_W      = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_ERR      = 2'd2;
  // 2'd3 is illegal and recovers to ST_RUN

endpackage

// File: rtl/hazard_sequencer_hazard_detect.sv
// hazard_detect: combinational data-hazard term for the ID-stage instruction.
// Ports:
//   fwdEnIn                  forwarding enabled (only load-use stalls)
//   idUseSrc1In/idUseSrc2In  ID reads src1 / src2
//   idSrc1In/idSrc2In        ID source register numbers
//   exWbEnIn/exMemREnIn      EX writes back / EX is a load
//   exDestIn                 EX destination
//   memWbEnIn/memDestIn      MEM writes back / MEM destination
//   hazardOut                ID must stall
module hazard_detect
  import hazard_sequencer_pkg::*;
(
  input  logic                  fwdEnIn,
  input  logic                  idUseSrc1In,
  input  logic                  idUseSrc2In,
  input  logic [REG_ADDR_W-1:0] idSrc1In,
  input  logic [REG_ADDR_W-1:0] idSrc2In,
  input  logic                  exWbEnIn,
  input  logic                  exMemREnIn,
  input  logic [REG_ADDR_W-1:0] exDestIn,
  input  logic                  memWbEnIn,
  input  logic [REG_ADDR_W-1:0] memDestIn,
  output logic                  hazardOut
);

  logic w_m1ex, w_m2ex, w_m1mem, w_m2mem;

  // r15 is compared like any other register number
  assign w_m1ex  = idUseSrc1In & exWbEnIn  & (exDestIn  == idSrc1In);
  assign w_m2ex  = idUseSrc2In & exWbEnIn  & (exDestIn  == idSrc2In);
  assign w_m1mem = idUseSrc1In & memWbEnIn & (memDestIn == idSrc1In);
  assign w_m2mem = idUseSrc2In & memWbEnIn & (memDestIn == idSrc2In);

  // With forwarding only a load in EX cannot be bypassed in time
  assign hazardOut = fwdEnIn ? (exMemREnIn & (w_m1ex | w_m2ex))
                             : (w_m1ex | w_m2ex | w_m1mem | w_m2mem);

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: per-cycle run / bubble / flush / freeze control for the
// 5-stage core, registered forwarding enable and memory-timeout flag.
// Ports:
//   clk, rstN                       clock, async active-low reset
//   fwdModeIn                       requested forwarding mode
//   id*/ex*/mem* hazard inputs      see hazard_detect
//   memReqIn, memReadyIn            MEM access pending / complete
//   branchTakenIn                   EX resolved a taken branch
//   clearErrIn                      leave ERR
//   forwardEnOut                    registered forwarding enable
//   holdFrontOut, bubbleOut         load-use stall controls
//   freezeAllOut, flushOut          global freeze / branch flush
//   errOut, stateOut                timeout flag, FSM state
// Optional (macro HAZARD_SEQ_PERF_EN): bubbleCntOut, freezeCntOut saturating
// cycle counters.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int WAIT_W      = DEF_WAIT_W
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  fwdModeIn,
  input  logic                  idUseSrc1In,
  input  logic                  idUseSrc2In,
  input  logic [REG_ADDR_W-1:0] idSrc1In,
  input  logic [REG_ADDR_W-1:0] idSrc2In,
  input  logic                  exWbEnIn,
  input  logic                  exMemREnIn,
  input  logic [REG_ADDR_W-1:0] exDestIn,
  input  logic                  memWbEnIn,
  input  logic [REG_ADDR_W-1:0] memDestIn,
  input  logic                  memReqIn,
  input  logic                  memReadyIn,
  input  logic                  branchTakenIn,
  input  logic                  clearErrIn,
  output logic                  forwardEnOut,
  output logic                  holdFrontOut,
  output logic                  bubbleOut,
  output logic                  freezeAllOut,
  output logic                  flushOut,
  output logic                  errOut,
  output logic [1:0]            stateOut
`ifdef HAZARD_SEQ_PERF_EN
  ,
  output logic [15:0]           bubbleCntOut,
  output logic [15:0]           freezeCntOut
`endif
);

  state_t              r_state, w_stateNxt;
  logic [WAIT_W-1:0]   r_waitCnt, w_waitCntNxt;
  logic                r_fwdEn, r_err, w_errNxt;
  logic                w_hazard, w_memStall;
  logic                w_hold, w_bubble, w_freeze, w_flush;

  hazard_detect u_hazard_detect (
    .fwdEnIn     (r_fwdEn),
    .idUseSrc1In (idUseSrc1In),
    .idUseSrc2In (idUseSrc2In),
    .idSrc1In    (idSrc1In),
    .idSrc2In    (idSrc2In),
    .exWbEnIn    (exWbEnIn),
    .exMemREnIn  (exMemREnIn),
    .exDestIn    (exDestIn),
    .memWbEnIn   (memWbEnIn),
    .memDestIn   (memDestIn),
    .hazardOut   (w_hazard)
  );

  assign w_memStall = memReqIn & ~memReadyIn;

  always_comb begin
    w_hold       = 1'b0;
    w_bubble     = 1'b0;
    w_freeze     = 1'b0;
    w_flush      = 1'b0;
    w_stateNxt   = r_state;
    w_waitCntNxt = r_waitCnt;
    w_errNxt     = r_err;
    case (r_state)
      ST_RUN: begin
        if (w_memStall) begin
          w_freeze     = 1'b1;
          w_stateNxt   = ST_MEM_WAIT;
          w_waitCntNxt = WAIT_W'(1);
        end else if (branchTakenIn) begin
          w_flush = 1'b1;          // flush clears ID/EX, so no bubble
        end else if (w_hazard) begin
          w_hold   = 1'b1;
          w_bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!memReadyIn) begin
          // frozen stages re-present branch/hazard later, so ignore them now
          w_freeze = 1'b1;
          if (r_waitCnt == WAIT_W'(MEM_TIMEOUT)) begin
            w_stateNxt = ST_ERR;
            w_errNxt   = 1'b1;
          end else begin
            w_waitCntNxt = r_waitCnt + 1'b1;
          end
        end else begin
          w_stateNxt   = ST_RUN;
          w_waitCntNxt = '0;
          if (branchTakenIn) begin
            w_flush = 1'b1;
          end else if (w_hazard) begin
            w_hold   = 1'b1;
            w_bubble = 1'b1;
          end
        end
      end
      ST_ERR: begin
        w_freeze = 1'b1;
        if (clearErrIn) begin
          w_stateNxt   = ST_RUN;
          w_errNxt     = 1'b0;
          w_waitCntNxt = '0;
        end
      end
      default: begin
        w_stateNxt   = ST_RUN;
        w_waitCntNxt = '0;
        w_errNxt     = 1'b0;
      end
    endcase
    // Outputs read as idle RUN while reset is held, even between edges
    if (!rstN) begin
      w_hold   = 1'b0;
      w_bubble = 1'b0;
      w_freeze = 1'b0;
      w_flush  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= ST_RUN;
      r_waitCnt <= '0;
      r_err     <= 1'b0;
      r_fwdEn   <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_waitCnt <= w_waitCntNxt;
      r_err     <= w_errNxt;
      // Mode only switches on a clean RUN cycle so a live stall keeps its rule
      if (r_state == ST_RUN && !w_hold && !w_freeze)
        r_fwdEn <= fwdModeIn;
    end
  end

`ifdef HAZARD_SEQ_PERF_EN
  logic [15:0] r_bubbleCnt, r_freezeCnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_bubbleCnt <= '0;
      r_freezeCnt <= '0;
    end else begin
      if (w_bubble && r_bubbleCnt != 16'hFFFF) r_bubbleCnt <= r_bubbleCnt + 16'd1;
      if (w_freeze && r_freezeCnt != 16'hFFFF) r_freezeCnt <= r_freezeCnt + 16'd1;
    end
  end

  assign bubbleCntOut = r_bubbleCnt;
  assign freezeCntOut = r_freezeCnt;
`else
  // no performance counters in this build
`endif

  assign forwardEnOut = r_fwdEn;
  assign holdFrontOut = w_hold;
  assign bubbleOut    = w_bubble;
  assign freezeAllOut = w_freeze;
  assign flushOut     = w_flush;
  assign errOut       = r_err;
  assign stateOut     = r_state;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer with hand-computed expectations.
module tb_hazard_sequencer;

  logic       clk, rstN;
  logic       fwdModeIn, idUseSrc1In, idUseSrc2In;
  logic [3:0] idSrc1In, idSrc2In, exDestIn, memDestIn;
  logic       exWbEnIn, exMemREnIn, memWbEnIn;
  logic       memReqIn, memReadyIn, branchTakenIn, clearErrIn;
  logic       forwardEnOut, holdFrontOut, bubbleOut, freezeAllOut, flushOut, errOut;
  logic [1:0] stateOut;
`ifdef HAZARD_SEQ_PERF_EN
  logic [15:0] bubbleCntOut, freezeCntOut;
`endif

  int total = 0;
  int bad   = 0;
  int nfreeze;

  hazard_sequencer dut (
    .clk(clk), .rstN(rstN), .fwdModeIn(fwdModeIn),
    .idUseSrc1In(idUseSrc1In), .idUseSrc2In(idUseSrc2In),
    .idSrc1In(idSrc1In), .idSrc2In(idSrc2In),
    .exWbEnIn(exWbEnIn), .exMemREnIn(exMemREnIn), .exDestIn(exDestIn),
    .memWbEnIn(memWbEnIn), .memDestIn(memDestIn),
    .memReqIn(memReqIn), .memReadyIn(memReadyIn),
    .branchTakenIn(branchTakenIn), .clearErrIn(clearErrIn),
    .forwardEnOut(forwardEnOut), .holdFrontOut(holdFrontOut),
    .bubbleOut(bubbleOut), .freezeAllOut(freezeAllOut), .flushOut(flushOut),
    .errOut(errOut), .stateOut(stateOut)
`ifdef HAZARD_SEQ_PERF_EN
    , .bubbleCntOut(bubbleCntOut), .freezeCntOut(freezeCntOut)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    idUseSrc1In = 0; idUseSrc2In = 0; idSrc1In = 0; idSrc2In = 0;
    exWbEnIn = 0; exMemREnIn = 0; exDestIn = 0;
    memWbEnIn = 0; memDestIn = 0;
    memReqIn = 0; memReadyIn = 0; branchTakenIn = 0; clearErrIn = 0;
  endtask

  initial begin
    rstN = 0; fwdModeIn = 0;
    idle_inputs();
    #2;
    chk("rst_state", stateOut, 0);
    chk("rst_fwd", forwardEnOut, 0);
    chk("rst_err", errOut, 0);
    chk("rst_freeze", freezeAllOut, 0);
    chk("rst_bubble", bubbleOut, 0);
    #6;
    rstN = 1; fwdModeIn = 1;
    tick();
    chk("fwd_on", forwardEnOut, 1);

    // load-use with forwarding on
    exMemREnIn = 1; exWbEnIn = 1; exDestIn = 4'd3; idUseSrc1In = 1; idSrc1In = 4'd3;
    #1;
    chk("lu_hold", holdFrontOut, 1);
    chk("lu_bubble", bubbleOut, 1);
    chk("lu_flush", flushOut, 0);
    tick();
    exMemREnIn = 0;
    #1;
    chk("alu_fwd_hold", holdFrontOut, 0);
    chk("alu_fwd_bubble", bubbleOut, 0);
    chk("fwd_kept", forwardEnOut, 1);

    // switch forwarding off on a clean cycle
    idle_inputs(); fwdModeIn = 0;
    tick();
    chk("fwd_off", forwardEnOut, 0);

    // no forwarding: MEM-stage dest matches src2
    memWbEnIn = 1; memDestIn = 4'd7; idSrc2In = 4'd7; idUseSrc2In = 1;
    #1;
    chk("nofwd_bubble", bubbleOut, 1);
    chk("nofwd_hold", holdFrontOut, 1);
    idUseSrc2In = 0;
    #1;
    chk("nofwd_unused_bubble", bubbleOut, 0);
    idUseSrc2In = 1; branchTakenIn = 1;
    #1;
    chk("br_flush", flushOut, 1);
    chk("br_bubble", bubbleOut, 0);
    chk("br_hold", holdFrontOut, 0);
    branchTakenIn = 0;

    // mode change under a live stall is deferred
    fwdModeIn = 1;
    #1;
    chk("stall_bubble", bubbleOut, 1);
    tick();
    chk("stall_fwd_kept0", forwardEnOut, 0);
    tick();
    chk("stall_fwd_kept1", forwardEnOut, 0);
    idle_inputs();
    tick();
    chk("fwd_after_stall", forwardEnOut, 1);

    // memory wait: ready after 4 frozen cycles
    memReqIn = 1; memReadyIn = 0; nfreeze = 0;
    for (int i = 0; i < 5; i++) begin
      memReadyIn    = (i == 4);
      branchTakenIn = (i == 2);
      #1;
      if (freezeAllOut) nfreeze++;
      chk($sformatf("mw_freeze%0d", i), freezeAllOut, (i < 4) ? 1 : 0);
      if (i < 4) chk($sformatf("mw_state%0d", i), stateOut, (i == 0) ? 0 : 1);
      if (i == 2) chk("mw_br_flush", flushOut, 0);
      tick();
    end
    idle_inputs();
    #1;
    chk("mw_back_run", stateOut, 0);
    chk("mw_freeze_total", nfreeze, 4);

    // timeout into ERR and clear
    memReqIn = 1; memReadyIn = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("to_state_wait", stateOut, 1);
    chk("to_err_pre", errOut, 0);
    tick();
    chk("to_state_err", stateOut, 2);
    chk("to_err", errOut, 1);
    chk("to_freeze", freezeAllOut, 1);
    memReadyIn = 1;
    tick();
    chk("err_ignores_ready", stateOut, 2);
    clearErrIn = 1;
    #1;
    chk("err_clear_freeze", freezeAllOut, 1);
    tick();
    chk("clr_state", stateOut, 0);
    chk("clr_err", errOut, 0);
    idle_inputs();
    tick();

    // async reset in the middle of MEM_WAIT
    memReqIn = 1; memReadyIn = 0;
    tick();
    chk("ar_in_wait", stateOut, 1);
    #3;
    rstN = 0;
    #1;
    chk("ar_state", stateOut, 0);
    chk("ar_freeze", freezeAllOut, 0);
    chk("ar_err", errOut, 0);
    chk("ar_fwd", forwardEnOut, 0);
    idle_inputs();
    #2;
    rstN = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
